// File: rtl/pixel_stream_arbiter.sv
// Two-channel round-robin arbiter: each grant moves exactly BURST pixels into one shared FIFO, tagged by source.
// Defining ARB_TIMEOUT_EN adds release of a grant whose FIFO stays empty for TIMEOUT cycles.
module pixel_stream_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int BURST      = 720,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in0_rd_en,
    input  logic                  in0_empty,
    input  logic [DATA_WIDTH-1:0] in0_dout,
    output logic                  in1_rd_en,
    input  logic                  in1_empty,
    input  logic [DATA_WIDTH-1:0] in1_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_chan,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [15:0] C_LAST_IDX = 16'(BURST - 1);
`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] C_WAIT_IDX = 16'(TIMEOUT - 1);
`endif

    state_t                r_state, w_state_nxt;
    logic                  r_grant, w_grant_nxt;
    logic                  r_last, w_last_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [15:0]           r_count, w_count_nxt;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]           r_wait_cnt, w_wait_cnt_nxt;
`endif

    logic                  w_pref_ch;
    logic                  w_pref_empty;
    logic                  w_other_empty;
    logic                  w_gnt_empty;
    logic [DATA_WIDTH-1:0] w_gnt_dout;

    // The channel not served last is preferred; dout only ever feeds the data register.
    assign w_pref_ch     = ~r_last;
    assign w_pref_empty  = r_last ? in0_empty : in1_empty;
    assign w_other_empty = r_last ? in1_empty : in0_empty;
    assign w_gnt_empty   = r_grant ? in1_empty : in0_empty;
    assign w_gnt_dout    = r_grant ? in1_dout : in0_dout;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_data     <= {DATA_WIDTH{1'b0}};
            r_count    <= 16'd0;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt <= 16'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_data     <= w_data_nxt;
            r_count    <= w_count_nxt;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt <= w_wait_cnt_nxt;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_data_nxt     = r_data;
        w_count_nxt    = r_count;
`ifdef ARB_TIMEOUT_EN
        w_wait_cnt_nxt = r_wait_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_pref_empty) begin
                    w_grant_nxt = w_pref_ch;
                    w_count_nxt = 16'd0;
                    w_state_nxt = S_READ;
                end else if (!w_other_empty) begin
                    w_grant_nxt = ~w_pref_ch;
                    w_count_nxt = 16'd0;
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (!w_gnt_empty) begin
                    w_data_nxt     = w_gnt_dout;
                    w_state_nxt    = S_WRITE;
`ifdef ARB_TIMEOUT_EN
                    w_wait_cnt_nxt = 16'd0;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // Stalled grant: truncate the burst so the other channel is not starved.
                    if (r_wait_cnt == C_WAIT_IDX) begin
                        w_last_nxt     = r_grant;
                        w_wait_cnt_nxt = 16'd0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                    end
`else
                    w_state_nxt = S_READ;
`endif
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    if (r_count == C_LAST_IDX) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + 16'd1;
                        w_state_nxt = S_READ;
                    end
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes decode from registered state plus empty/full flags only.
    always_comb begin
        in0_rd_en = 1'b0;
        in1_rd_en = 1'b0;
        out_wr_en = 1'b0;
        out_din   = {DATA_WIDTH{1'b0}};
        out_chan  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_READ: begin
                if (!w_gnt_empty) begin
                    in0_rd_en = ~r_grant;
                    in1_rd_en = r_grant;
                end else begin
                    in0_rd_en = 1'b0;
                    in1_rd_en = 1'b0;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    out_din   = r_data;
                    out_chan  = r_grant;
                end else begin
                    out_wr_en = 1'b0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Scoreboard bench for pixel_stream_arbiter (BURST=4, TIMEOUT=8); input FIFOs are modelled as show-ahead queues.
module tb_pixel_stream_arbiter;
    localparam int DW      = 24;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in0_rd_en, in1_rd_en, out_wr_en, out_chan, busy;
    logic          in0_empty = 1'b1, in1_empty = 1'b1, out_full = 1'b0;
    logic [DW-1:0] in0_dout = '0, in1_dout = '0, out_din;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW:0]   exp_q[$];

    int errors = 0, checks = 0, wr_count = 0;
    bit pend0 = 1'b0, pend1 = 1'b0, seen_rd0 = 1'b0;

    pixel_stream_arbiter #(.DATA_WIDTH(DW), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in0_rd_en(in0_rd_en), .in0_empty(in0_empty), .in0_dout(in0_dout),
        .in1_rd_en(in1_rd_en), .in1_empty(in1_empty), .in1_dout(in1_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
        .out_chan(out_chan), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic upd();
        in0_empty = (q0.size() == 0);
        in1_empty = (q1.size() == 0);
        in0_dout  = (q0.size() > 0) ? q0[0] : '0;
        in1_dout  = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic push0(input logic [DW-1:0] d);
        q0.push_back(d);
        upd();
    endtask

    task automatic push1(input logic [DW-1:0] d);
        q1.push_back(d);
        upd();
    endtask

    task automatic expect_px(input logic c, input logic [DW-1:0] d);
        exp_q.push_back({c, d});
    endtask

    // Waits on falling edges until wr_count reaches target; cyc is the edge index, -1 on expiry.
    task automatic wait_writes(input int target, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (wr_count >= target) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Mid-cycle monitor: scoreboard pops on writes, strobe exclusivity, read-strobe recording.
    always @(negedge clock) begin
        pend0 = in0_rd_en;
        pend1 = in1_rd_en;
        if (in0_rd_en) seen_rd0 = 1'b1;
        if (in0_rd_en || in1_rd_en || out_wr_en) begin
            checks++;
            if ((in0_rd_en && in1_rd_en) || ((in0_rd_en || in1_rd_en) && out_wr_en) ||
                (in0_rd_en && in0_empty) || (in1_rd_en && in1_empty)) begin
                errors++;
                $display("FAIL strobes: rd0=%b rd1=%b wr=%b e0=%b e1=%b", in0_rd_en, in1_rd_en,
                         out_wr_en, in0_empty, in1_empty);
            end
        end
        if (out_wr_en) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got chan=%0d data=%h, required none", out_chan, out_din);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({out_chan, out_din} !== e) begin
                    errors++;
                    $display("FAIL write_data: got chan=%0d data=%h, required chan=%0d data=%h",
                             out_chan, out_din, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    // Input FIFO read side: pop what the DUT read in the cycle just ended.
    always @(posedge clock) begin
        #1;
        if (pend0 && q0.size() > 0) begin
            q0.delete(0);
        end
        if (pend1 && q1.size() > 0) begin
            q1.delete(0);
        end
        pend0 = 1'b0;
        pend1 = 1'b0;
        upd();
    end

    task automatic test_reset();
        for (int i = 1; i <= 8; i++) begin
            push0(24'(i));
            push1(24'h100000 | 24'(i));
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({in0_rd_en, in1_rd_en, out_wr_en, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got rd0/rd1/wr/busy=%b, required 0000",
                     {in0_rd_en, in1_rd_en, out_wr_en, busy});
        end
        checks++;
        if ({out_chan, out_din} !== 25'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", {out_chan, out_din});
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 1; i <= 4; i++) expect_px(1'b0, 24'(4 * b + i));
            for (int i = 1; i <= 4; i++) expect_px(1'b1, 24'h100000 | 24'(4 * b + i));
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({in0_rd_en, in1_rd_en} !== 2'b10) begin
            errors++;
            $display("FAIL first_grant: got rd0/rd1=%b, required 10", {in0_rd_en, in1_rd_en});
        end
    endtask

    task automatic test_alternation();
        int cyc;
        wait_writes(16, 100, cyc);
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL alternation_time: got 16th write at edge %0d, required 33", cyc);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL alternation_end: got busy=%b pending=%0d, required 0 and 0", busy, exp_q.size());
        end
    endtask

    task automatic test_single_requester();
        int cyc;
        int base;
        @(posedge clock);
        #1;
        seen_rd0 = 1'b0;
        base = wr_count;
        for (int i = 1; i <= 8; i++) begin
            push1(24'h200000 | 24'(i));
            expect_px(1'b1, 24'h200000 | 24'(i));
        end
        wait_writes(base + 8, 60, cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL single_time: got 8th write at edge %0d, required 17", cyc);
        end
        checks++;
        if (seen_rd0 !== 1'b0) begin
            errors++;
            $display("FAIL single_rd0: got in0_rd_en seen=%b, required 0", seen_rd0);
        end
    endtask

    task automatic test_back_pressure();
        int cyc;
        int base;
        @(posedge clock);
        #1;
        base = wr_count;
        for (int i = 1; i <= 4; i++) begin
            push0(24'h300000 | 24'(i));
            expect_px(1'b0, 24'h300000 | 24'(i));
        end
        wait_writes(base + 1, 20, cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL bp_first: got %0d writes, required %0d", wr_count - base, 1);
        end
        @(posedge clock);
        #1;
        out_full = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({out_wr_en, in0_rd_en, in1_rd_en, busy} !== 4'b0001) begin
                errors++;
                $display("FAIL bp_hold: got wr/rd0/rd1/busy=%b, required 0001",
                         {out_wr_en, in0_rd_en, in1_rd_en, busy});
            end
        end
        @(posedge clock);
        #1;
        out_full = 1'b0;
        wait_writes(base + 4, 20, cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL bp_resume: got 4th write at edge %0d, required 4", cyc);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (wr_count != base + 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d writes pending=%0d, required 4 and 0", wr_count - base, exp_q.size());
        end
    endtask

    task automatic test_starvation();
        int cyc;
        int base;
        @(posedge clock);
        #1;
        base = wr_count;
        push0(24'h400001);
        push0(24'h400002);
        expect_px(1'b0, 24'h400001);
        expect_px(1'b0, 24'h400002);
        wait_writes(base + 2, 20, cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL starve_first: got %0d writes, required 2", wr_count - base);
        end
        @(posedge clock);
        #1;
        for (int i = 1; i <= 4; i++) push1(24'h500000 | 24'(i));
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) expect_px(1'b1, 24'h500000 | 24'(i));
        cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (in1_rd_en) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL timeout_grant: got first rd1 at edge %0d, required 9", cyc);
        end
        wait_writes(base + 6, 40, cyc);
        @(posedge clock);
        #1;
        for (int i = 3; i <= 6; i++) begin
            push0(24'h400000 | 24'(i));
            expect_px(1'b0, 24'h400000 | 24'(i));
        end
        wait_writes(base + 10, 60, cyc);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if ({busy, in0_rd_en, in1_rd_en, out_wr_en} !== 4'b1000) begin
                errors++;
                $display("FAIL starve_hold: got busy/rd0/rd1/wr=%b, required 1000",
                         {busy, in0_rd_en, in1_rd_en, out_wr_en});
            end
        end
        @(posedge clock);
        #1;
        push0(24'h400003);
        push0(24'h400004);
        expect_px(1'b0, 24'h400003);
        expect_px(1'b0, 24'h400004);
        for (int i = 1; i <= 4; i++) expect_px(1'b1, 24'h500000 | 24'(i));
        wait_writes(base + 8, 60, cyc);
`endif
        checks++;
        if (cyc < 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_done: got edge %0d pending=%0d, required completion", cyc, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        int base;
        @(posedge clock);
        #1;
        base = wr_count;
        for (int i = 1; i <= 6; i++) push0(24'h600000 | 24'(i));
        for (int i = 1; i <= 4; i++) push1(24'h700000 | 24'(i));
        expect_px(1'b0, 24'h600001);
        expect_px(1'b0, 24'h600002);
        wait_writes(base + 2, 20, cyc);
        @(posedge clock);
        #1;
        checks++;
        if (in0_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd0: got in0_rd_en=%b, required 1", in0_rd_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({in0_rd_en, in1_rd_en, out_wr_en, busy, out_chan, out_din} !== 28'd0) begin
            errors++;
            $display("FAIL mid_reset_out: got %h, required 0",
                     {in0_rd_en, in1_rd_en, out_wr_en, busy, out_chan, out_din});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 3; i <= 6; i++) expect_px(1'b0, 24'h600000 | 24'(i));
        for (int i = 1; i <= 4; i++) expect_px(1'b1, 24'h700000 | 24'(i));
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got busy=%b, required 0", busy);
        end
        @(negedge clock);
        checks++;
        if ({in0_rd_en, in1_rd_en} !== 2'b10) begin
            errors++;
            $display("FAIL mid_regrant: got rd0/rd1=%b, required 10", {in0_rd_en, in1_rd_en});
        end
        wait_writes(base + 10, 60, cyc);
        checks++;
        if (cyc !== 15 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_restart: got 8th write at edge %0d pending=%0d, required 15 and 0", cyc, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_single_requester();
        test_back_pressure();
        test_starvation();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
